load_store_unit: RTL

CPU-side initiator for the single-port data RAM (word-addressed, combinational read, write on rising clock when write-enabled). Accepts byte/halfword/word load and store requests from the execute stage over a valid/ready handshake and drives the RAM address, data and write-enable. Sub-word stores use a two-step read-modify-write. Loads are returned sign- or zero-extended. Misaligned, out-of-range and illegal requests are rejected without touching memory.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_align.sv | 56 +++++
 rtl/load_store_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state encoding
// and the funct3 legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Stores have only the signed-looking codes; unsigned variants exist for loads only.
  function automatic logic isLegalF3(input logic we, input logic [2:0] funct3);
    logic legal;
    legal = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = !we;
      default:          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data, and merges
// sub-word store data into an old RAM word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [15:0] i_wdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_loadData,
  output logic [31:0] o_mergedWord
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_off)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

    case (i_funct3)
      F3_B:    o_loadData = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_loadData = {24'd0, w_byte};
      F3_H:    o_loadData = {{16{w_half[15]}}, w_half};
      F3_HU:   o_loadData = {16'd0, w_half};
      default: o_loadData = i_word;
    endcase
  end

  // Only the addressed lane(s) change; everything else keeps the old word.
  always_comb begin
    o_mergedWord = i_word;
    case (i_funct3)
      F3_B: begin
        case (i_off)
          2'd1:    o_mergedWord[15:8]  = i_wdata[7:0];
          2'd2:    o_mergedWord[23:16] = i_wdata[7:0];
          2'd3:    o_mergedWord[31:24] = i_wdata[7:0];
          default: o_mergedWord[7:0]   = i_wdata[7:0];
        endcase
      end
      F3_H: begin
        if (i_off[1]) o_mergedWord[31:16] = i_wdata;
        else          o_mergedWord[15:0]  = i_wdata;
      end
      default: o_mergedWord = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// CPU-side initiator for the single-port data RAM: byte/half/word loads and
// stores over valid/ready, with read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int width     = 32,
  parameter int addrWidth = 8
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [width-1:0]     req_wdata,
  output logic                 rsp_valid,
  output logic [width-1:0]     rsp_rdata,
  output logic                 rsp_err,
  output logic [addrWidth-1:0] mem_addr,
  output logic [width-1:0]     mem_din,
  output logic                 mem_wren,
  input  logic [width-1:0]     mem_dout
);

  state_t               r_state;
  logic                 r_we;
  logic [2:0]           r_funct3;
  logic [1:0]           r_off;
  logic [15:0]          r_wdata;
  logic                 r_rspValid;
  logic [width-1:0]     r_rspRdata;
  logic                 r_rspErr;
  logic [addrWidth-1:0] r_memAddr;
  logic [width-1:0]     r_memDin;
  logic                 r_memWren;

  logic        w_misHalf;
  logic        w_misWord;
  logic        w_outOfRange;
  logic        w_reqErr;
  logic [31:0] w_loadData;
  logic [31:0] w_mergedWord;

  // funct3[1:0]==01 covers both LH and LHU (and SH).
  assign w_misHalf    = (req_funct3[1:0] == 2'b01) && req_addr[0];
  assign w_misWord    = (req_funct3 == F3_W) && (req_addr[1:0] != 2'b00);
  assign w_outOfRange = (req_addr >> (addrWidth + 2)) != 32'd0;
  assign w_reqErr     = !isLegalF3(req_we, req_funct3) || w_misHalf || w_misWord || w_outOfRange;

  lsu_align u_align (
    .i_word       (mem_dout),
    .i_wdata      (r_wdata),
    .i_off        (r_off),
    .i_funct3     (r_funct3),
    .o_loadData   (w_loadData),
    .o_mergedWord (w_mergedWord)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_funct3   <= 3'd0;
      r_off      <= 2'd0;
      r_wdata    <= 16'd0;
      r_rspValid <= 1'b0;
      r_rspRdata <= '0;
      r_rspErr   <= 1'b0;
      r_memAddr  <= '0;
      r_memDin   <= '0;
      r_memWren  <= 1'b0;
    end else begin
      r_rspValid <= 1'b0;
      r_memWren  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_off    <= req_addr[1:0];
            r_wdata  <= req_wdata[15:0];
            if (w_reqErr) begin
              r_rspValid <= 1'b1;
              r_rspErr   <= 1'b1;
              r_rspRdata <= '0;
              r_state    <= S_RESP;
            end else begin
              r_memAddr <= req_addr[addrWidth+1:2];
              r_state   <= S_ACCESS;
              // A full-word store needs no old data, so it writes during ACCESS.
              if (req_we && (req_funct3 == F3_W)) begin
                r_memWren <= 1'b1;
                r_memDin  <= req_wdata;
              end
            end
          end
        end
        S_ACCESS: begin
          if (r_we && (r_funct3 != F3_W)) begin
            r_memDin  <= w_mergedWord;
            r_memWren <= 1'b1;
            r_state   <= S_WRITE;
          end else begin
            r_rspValid <= 1'b1;
            r_rspErr   <= 1'b0;
            r_rspRdata <= r_we ? '0 : w_loadData;
            r_state    <= S_RESP;
          end
        end
        S_WRITE: begin
          r_rspValid <= 1'b1;
          r_rspErr   <= 1'b0;
          r_rspRdata <= '0;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rspRdata;
  assign rsp_err   = r_rspErr;
  assign mem_addr  = r_memAddr;
  assign mem_din   = r_memDin;
  assign mem_wren  = r_memWren;

endmodule
